// File: rtl/niosii_microprocessor_data_in_pkg.sv
// ---------------------------------------------------------------------------
// niosII_pio_pkg
// Shared constants for the Nios II parallel I/O ports.
//   PIO_OFS_*  : Avalon-MM word offsets of the PIO register map.
//   EDGE_*     : edge-capture selector values for the EDGE_TYPE parameter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package niosII_pio_pkg;

  localparam logic [1:0] PIO_OFS_DATA    = 2'd0;
  localparam logic [1:0] PIO_OFS_DIR     = 2'd1;
  localparam logic [1:0] PIO_OFS_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_OFS_EDGE    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/niosii_microprocessor_data_in_sync_edge.sv
// ---------------------------------------------------------------------------
// niosII_pio_sync_edge
// Two-flop synchronizer for an asynchronous input bus, followed by a
// "previous value" register and a per-bit edge detector.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   in_port   in   [WIDTH] external asynchronous bus
//   data      out  [WIDTH] synchronized value (second stage)
//   edge_vec  out  [WIDTH] one-cycle edge strobes, per bit
// Parameters: WIDTH, EDGE_TYPE (EDGE_RISE/EDGE_FALL/EDGE_ANY), RESET_VALUE.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module niosII_pio_sync_edge
  import niosII_pio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] edge_vec
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] prev_reg;

  // prev also resets to RESET_VALUE so the first edge after reset is
  // judged against the reset value of the synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= RESET_VALUE;
      sync2_reg <= RESET_VALUE;
      prev_reg  <= RESET_VALUE;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign data = sync2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign edge_vec[gi] = ~sync2_reg[gi] & prev_reg[gi];
      end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign edge_vec[gi] = sync2_reg[gi] ^ prev_reg[gi];
      end else begin : g_rise
        assign edge_vec[gi] = sync2_reg[gi] & ~prev_reg[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/niosii_microprocessor_data_in.sv
// ---------------------------------------------------------------------------
// niosii_microprocessor_data_in
// Avalon-MM slave parallel input port with edge capture and level irq.
// Register map (word offset):
//   0 data         : synchronized input, read only
//   1 reserved     : reads 0
//   2 irq_mask     : RW (only when NIOSII_DATA_IN_IRQ_EN is defined)
//   3 edge_capture : read, write-1-to-clear per bit
// Ports:
//   clk, reset_n (async active-low), address[2], chipselect, write_n,
//   writedata[32], in_port[WIDTH], readdata[32] (combinational), irq.
// Build option: define NIOSII_DATA_IN_IRQ_EN to get the interrupt mask and
// irq output; otherwise offset 2 reads 0 and irq is tied low.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module niosii_microprocessor_data_in
  import niosII_pio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             wr_en;
  logic             wr_edge;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] edge_capture_reg;
  logic [WIDTH-1:0] edge_capture_next;
  logic [WIDTH-1:0] irq_mask;

  assign wr_en   = chipselect && !write_n;
  assign wr_edge = wr_en && (address == PIO_OFS_EDGE);

  niosII_pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .RESET_VALUE (RESET_VALUE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .data     (data),
    .edge_vec (edge_vec)
  );

  // A new edge wins over a clear of the same bit, so no edge is lost.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cap
      assign edge_capture_next[gi] = edge_vec[gi] |
             (edge_capture_reg[gi] & ~(wr_edge & writedata[gi]));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture_reg <= '0;
    end else begin
      edge_capture_reg <= edge_capture_next;
    end
  end

`ifdef NIOSII_DATA_IN_IRQ_EN
  logic [WIDTH-1:0] irq_mask_reg;
  logic             irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_en && (address == PIO_OFS_IRQMASK)) begin
        irq_mask_reg <= writedata[WIDTH-1:0];
      end
      irq_reg <= |(edge_capture_reg & irq_mask_reg);
    end
  end

  assign irq_mask = irq_mask_reg;
  assign irq      = irq_reg;
`else
  assign irq_mask = '0;
  assign irq      = 1'b0;
`endif

  // Read mux is independent of chipselect, matching the output PIOs.
  always_comb begin
    readdata = '0;
    case (address)
      PIO_OFS_DATA:    readdata[WIDTH-1:0] = data;
      PIO_OFS_IRQMASK: readdata[WIDTH-1:0] = irq_mask;
      PIO_OFS_EDGE:    readdata[WIDTH-1:0] = edge_capture_reg;
      default:         readdata = '0;
    endcase
  end

  // Upper write-data bits beyond WIDTH are architecturally ignored.
  logic unused_writedata;
  assign unused_writedata = &{1'b0, writedata};

endmodule

// File: doc/niosii_microprocessor_data_in.md
Name: niosII_microprocessor_data_in

Overview:
- Avalon-MM slave parallel input port; the read-side counterpart of the existing 11-bit address/data output PIOs.
- Samples an external bus (e.g. SRAM data-out) through a two-flop synchronizer and detects edges per bit.
- Latches detected edges in a capture register and raises a maskable level interrupt to the Nios II.

Parameters:
- WIDTH, 16, input port width (1..32).
- EDGE_TYPE, 0, edge capture select: 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 0, reset value of both synchronizer stages (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  external asynchronous input bus.
- readdata  out  32  read data; combinational, zero read latency.
- irq  out  1  level interrupt, active high.

Behaviour:
- Single clock domain. reset_n is asynchronous, active low; all flops reset on its falling edge.
- Reset values: sync1 = sync2 = RESET_VALUE; prev = RESET_VALUE; edge_capture = 0; irq_mask = 0; irq = 0.
- Synchronizer: sync1 <= in_port; sync2 <= sync1; prev <= sync2. A change on in_port is visible at offset 0 two clocks later.
- Edge detect, per bit:
  - rising: sync2 & ~prev
  - falling: ~sync2 & prev
  - any: sync2 ^ prev
- Register map (address):
  - 0 = data: read sync2, zero-extended; writes ignored.
  - 1 = reserved: reads 0; writes ignored.
  - 2 = irq_mask: RW, bits [WIDTH-1:0].
  - 3 = edge_capture: read; write-1-to-clear per bit.
- Write qualifier: chipselect && !write_n. No wait states; every access completes in its cycle.
- Edge capture update:
  - edge_capture[i] <= edge[i] | (edge_capture[i] & ~(wr3 & writedata[i])).
  - An edge in the same cycle as a clear of that bit: the set wins, so no edge is lost.
- readdata: mux of the selected register, upper 32-WIDTH bits zero. The mux is active regardless of chipselect, as in the output PIOs.
- irq: registered; irq <= |(edge_capture & irq_mask). It asserts one clock after the capture bit sets, and deasserts one clock after a clear or unmask.
- Boundary conditions:
  - A stable input never sets a capture bit.
  - A pulse narrower than one clock may be missed (no guarantee).
  - Reset mid-operation clears capture and mask; the first edge after reset is judged against RESET_VALUE.
  - A bit already set in edge_capture stays 1 on further edges (sticky).

Optional Feature:
- Macro: NIOSII_DATA_IN_IRQ_EN.
- Defined: irq_mask register at offset 2 and irq output behave as specified above.
- Undefined: no mask flops; offset 2 reads 0 and writes are ignored; irq tied 0. Edge capture still operates so software can poll it.

Decomposition:
- Shared package niosII_pio_pkg holds:
  - offset constants PIO_OFS_DATA = 0, PIO_OFS_DIR = 1, PIO_OFS_IRQMASK = 2, PIO_OFS_EDGE = 3;
  - edge-type constants EDGE_RISE = 0, EDGE_FALL = 1, EDGE_ANY = 2.
- One sub-module, niosII_pio_sync_edge (params WIDTH, EDGE_TYPE, RESET_VALUE): the synchronizer, prev register and edge vector.
- Top level keeps the register file, read mux and irq.

Test Plan:
- Reset with in_port = 16'hA5A5, then release → offset 0 reads 0 for 2 clocks, then 0x0000A5A5; offset 3 reads 0x0000A5A5 (rising edges vs RESET_VALUE 0).
- EDGE_TYPE = 0: write 0xFFFF to offset 3 to clear; drive bit 3 0→1→0 → offset 3 reads 0x00000008 only; falling edge adds nothing.
- Mask 0x0008 written to offset 2; bit 3 rises → irq high 4 clocks after in_port change (2 sync + capture + irq reg); write 0x0008 to offset 3 → irq low one clock later.
- Clear bit 3 in the same cycle a new rising edge on bit 3 is detected → bit 3 remains 1; irq stays high.
- Write 0x12345678 to offset 0 and to offset 1 → no state change; offset 1 reads 0; without NIOSII_DATA_IN_IRQ_EN, offset 2 reads 0 and irq stays 0 throughout.
- Assert reset_n low mid-transfer with capture 0x00FF and mask 0xFFFF → readdata at offsets 2 and 3 and irq are 0 immediately, without waiting for a clock.
